usermem_arbiter: RTL and testbench

Two-requester arbiter for the single-port user memory. It shares the memory between the CPU control unit and a second master, such as a DMA or peripheral engine. Arbitration is round-robin with an optional lock that lets one requester keep the memory for short bursts, bounded by a hold limit. Read data comes back through a registered return path tagged to the winning requester.

---
 rtl/usermem_arbiter_pkg.sv | 12 +
 rtl/usermem_arbiter_rr_pick2.sv | 41 ++++
 rtl/usermem_arbiter.sv | 138 +++++++++++++
 tb/tb_usermem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usermem_arbiter_pkg.sv
// usermem_arbiter_pkg
// Shared definitions for the user-memory arbiter: requester identifiers,
// the default lock hold limit and the width of the hold counter.
// No ports (package).
package usermem_arbiter_pkg;

  localparam logic        REQ_CPU          = 1'b0;
  localparam logic        REQ_DMA          = 1'b1;
  localparam int unsigned MAX_HOLD_DEFAULT = 4;
  localparam int          HOLD_W           = 4;

endpackage

// File: rtl/usermem_arbiter_rr_pick2.sv
// usermem_arbiter_rr_pick2
// Combinational two-way round-robin pick with a bounded lock.
// Ports:
//   req      in  [1:0]  request vector, bit 0 = CPU, bit 1 = DMA
//   lock     in  [1:0]  lock vector, same bit order
//   last     in  1      winner of the most recent grant
//   hold_cnt in  HOLD_W consecutive contested grants to the current owner
//   gnt_any  out 1      some requester wins this cycle
//   winner   out 1      id of the winning requester (valid when gnt_any)
module usermem_arbiter_rr_pick2
  import usermem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  logic              last,
  input  logic [HOLD_W-1:0] hold_cnt,
  output logic              gnt_any,
  output logic              winner
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  always_comb begin
    gnt_any = req[0] | req[1];
    winner  = REQ_CPU;
    if (req == 2'b10) begin
      winner = REQ_DMA;
    end else if (req == 2'b11) begin
      // Contested: the previous owner keeps the memory only while it locks
      // and has not used up its hold budget; otherwise the other side wins.
      if (lock[last] && (hold_cnt < HOLD_LIM)) begin
        winner = last;
      end else begin
        winner = ~last;
      end
    end
  end

endmodule

// File: rtl/usermem_arbiter.sv
// usermem_arbiter
// Shares a single-port registered user memory between the CPU control unit
// and a second master (DMA). Round-robin arbitration with a bounded lock,
// zero-latency grant, and a one-cycle registered read return tagged to the
// requester that issued the read.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/rw/lock/addr/wdata      CPU request side (in)
//   cpu_gnt, cpu_rvalid, cpu_rdata  CPU response side (out)
//   dma_*                           second requester, same meaning
//   mem_en/rw/addr/wdata            memory command (out)
//   mem_rdata                       memory read data, one cycle after a read
module usermem_arbiter
  import usermem_arbiter_pkg::*;
#(
  parameter int          AW       = 8,
  parameter int          DW       = 8,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_rw,
  input  logic          cpu_lock,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_rw,
  input  logic          dma_lock,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic [DW-1:0]     cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]     dma_rdata_q, dma_rdata_d;

  logic gnt_any;
  logic winner;
  logic grant;
  logic other_req;
  logic win_rw;

  usermem_arbiter_rr_pick2 #(
    .MAX_HOLD (MAX_HOLD)
  ) u_pick (
    .req      ({dma_req, cpu_req}),
    .lock     ({dma_lock, cpu_lock}),
    .last     (last_q),
    .hold_cnt (hold_cnt_q),
    .gnt_any  (gnt_any),
    .winner   (winner)
  );

  // Reset suppresses the grant so no access reaches the memory.
  assign grant     = gnt_any & ~reset;
  assign other_req = (winner == REQ_DMA) ? cpu_req : dma_req;
  assign win_rw    = (winner == REQ_DMA) ? dma_rw : cpu_rw;

  // Stage 0: grant and memory command, combinational from the requests.
  always_comb begin
    cpu_gnt   = grant & (winner == REQ_CPU);
    dma_gnt   = grant & (winner == REQ_DMA);
    mem_en    = grant;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant) begin
      mem_rw    = win_rw;
      mem_addr  = (winner == REQ_DMA) ? dma_addr : cpu_addr;
      mem_wdata = (winner == REQ_DMA) ? dma_wdata : cpu_wdata;
    end
  end

  always_comb begin
    last_d     = last_q;
    hold_cnt_d = '0;
    rd_pend_d  = grant & ~win_rw;
    rd_owner_d = grant ? winner : rd_owner_q;
    if (grant) begin
      last_d = winner;
      // Count only grants that keep the same owner against a waiting rival;
      // an uncontested lock therefore never accumulates.
      if ((winner == last_q) && other_req) begin
        hold_cnt_d = (hold_cnt_q >= HOLD_LIM) ? HOLD_LIM : hold_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: read return; the owner sees mem_rdata directly and the
  // per-requester register keeps it afterwards.
  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    if (rd_pend_q && (rd_owner_q == REQ_CPU)) cpu_rdata_d = mem_rdata;
    if (rd_pend_q && (rd_owner_q == REQ_DMA)) dma_rdata_d = mem_rdata;
  end

  assign cpu_rvalid = ~reset & rd_pend_q & (rd_owner_q == REQ_CPU);
  assign dma_rvalid = ~reset & rd_pend_q & (rd_owner_q == REQ_DMA);
  assign cpu_rdata  = reset ? '0 : cpu_rdata_d;
  assign dma_rdata  = reset ? '0 : dma_rdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= REQ_DMA;
      hold_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= REQ_CPU;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_usermem_arbiter.sv
// tb_usermem_arbiter
// Directed bench for usermem_arbiter with a registered memory and a
// transaction-level reference model checked on every falling edge.
module tb_usermem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int MAXH = 4;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_rw, cpu_lock;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req, dma_rw, dma_lock;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_en, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  usermem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAXH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_rw     (cpu_rw),
    .cpu_lock   (cpu_lock),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_rw     (dma_rw),
    .dma_lock   (dma_lock),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_en     (mem_en),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered single-port memory driven by the DUT, plus a shadow copy
  // that only the reference model writes.
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] smem [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i) ^ 8'hA5;
      smem[i] = 8'(i) ^ 8'hA5;
    end
    mem[8'h10]  = 8'h5A;
    smem[8'h10] = 8'h5A;
  end

  always @(posedge clk) begin
    if (mem_en && mem_rw) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_rw) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who is entitled to the memory this cycle.
  function automatic logic [1:0] model_pick(input logic c, input logic d,
                                            input logic cl, input logic dl,
                                            input logic last, input int hold);
    logic owner_lock;
    if (!c && !d) return 2'b00;
    if (c && !d)  return 2'b10;
    if (!c && d)  return 2'b11;
    owner_lock = last ? dl : cl;
    if (owner_lock && hold < MAXH) return {1'b1, last};
    return {1'b1, ~last};
  endfunction

  logic          m_last, m_pend, m_powner;
  int            m_hold;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_crd, m_drd;
  logic          e_v, e_w, e_rw;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          e_crv, e_drv;

  always @(negedge clk) begin
    if (reset) begin
      e_v = 1'b0; e_w = 1'b0; e_rw = 1'b0; e_addr = '0; e_wdata = '0;
      e_crv = 1'b0; e_drv = 1'b0;
      m_crd = '0; m_drd = '0;
    end else begin
      {e_v, e_w} = model_pick(cpu_req, dma_req, cpu_lock, dma_lock, m_last, m_hold);
      e_rw    = e_v ? (e_w ? dma_rw : cpu_rw) : 1'b0;
      e_addr  = e_v ? (e_w ? dma_addr : cpu_addr) : '0;
      e_wdata = e_v ? (e_w ? dma_wdata : cpu_wdata) : '0;
      e_crv   = m_pend && !m_powner;
      e_drv   = m_pend && m_powner;
      if (e_crv) m_crd = smem[m_paddr];
      if (e_drv) m_drd = smem[m_paddr];
    end
    chk("cpu_gnt",    cpu_gnt,    e_v && !e_w);
    chk("dma_gnt",    dma_gnt,    e_v && e_w);
    chk("mem_en",     mem_en,     e_v);
    chk("mem_rw",     mem_rw,     e_rw);
    chk("mem_addr",   mem_addr,   e_addr);
    chk("mem_wdata",  mem_wdata,  e_wdata);
    chk("cpu_rvalid", cpu_rvalid, e_crv);
    chk("dma_rvalid", dma_rvalid, e_drv);
    chk("cpu_rdata",  cpu_rdata,  m_crd);
    chk("dma_rdata",  dma_rdata,  m_drd);
    if (reset) begin
      m_last = 1'b1; m_hold = 0; m_pend = 1'b0; m_powner = 1'b0; m_paddr = '0;
    end else begin
      m_pend   = e_v && !e_rw;
      m_powner = e_w;
      m_paddr  = e_addr;
      if (e_v && e_rw) smem[e_addr] = e_wdata;
      if (e_v) begin
        if (e_w == m_last && (e_w ? cpu_req : dma_req))
          m_hold = (m_hold >= MAXH) ? MAXH : m_hold + 1;
        else
          m_hold = 0;
        m_last = e_w;
      end else begin
        m_hold = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_rw = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_rw = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [9:0] lock_pat;

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    #1;
    chk("reset_cpu_gnt", cpu_gnt, 1'b0);
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_cpu_rdata", cpu_rdata, 8'h00);
    chk("reset_last", dut.last_q, 1'b1);
    chk("reset_hold", dut.hold_cnt_q, 4'd0);
    tick();
    reset = 1'b0;

    // Single CPU read from 0x10.
    cpu_req = 1; cpu_rw = 0; cpu_addr = 8'h10;
    #1;
    chk("rd_cpu_gnt", cpu_gnt, 1'b1);
    chk("rd_mem_addr", mem_addr, 8'h10);
    tick();
    idle_inputs();
    #1;
    chk("rd_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("rd_cpu_rdata", cpu_rdata, 8'h5A);
    chk("rd_dma_rvalid", dma_rvalid, 1'b0);
    tick();

    // Tie after reset: CPU first, then alternation.
    do_reset();
    cpu_req = 1; cpu_addr = 8'h20; dma_req = 1; dma_addr = 8'h21;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("tie_cpu_gnt", cpu_gnt, (k % 2) == 0);
      chk("tie_dma_gnt", dma_gnt, (k % 2) == 1);
      tick();
    end
    idle_inputs();
    tick();

    // Lock bound: DMA holds for 1 + MAX_HOLD grants, CPU gets one slot.
    do_reset();
    cpu_req = 1; cpu_addr = 8'h30;
    tick();
    cpu_addr = 8'h31; dma_req = 1; dma_addr = 8'h32; dma_lock = 1;
    lock_pat = 10'b1111011111;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("lock_dma_gnt", dma_gnt, lock_pat[k]);
      chk("lock_cpu_gnt", cpu_gnt, !lock_pat[k]);
      tick();
    end
    idle_inputs();
    tick();

    // DMA write, CPU idle.
    dma_req = 1; dma_rw = 1; dma_addr = 8'hFE; dma_wdata = 8'h33;
    #1;
    chk("wr_mem_en", mem_en, 1'b1);
    chk("wr_mem_rw", mem_rw, 1'b1);
    chk("wr_mem_addr", mem_addr, 8'hFE);
    chk("wr_mem_wdata", mem_wdata, 8'h33);
    tick();
    idle_inputs();
    #1;
    chk("wr_dma_rvalid", dma_rvalid, 1'b0);
    chk("wr_cpu_rvalid", cpu_rvalid, 1'b0);
    tick();

    // DMA reads the written location back.
    dma_req = 1; dma_rw = 0; dma_addr = 8'hFE;
    tick();
    idle_inputs();
    #1;
    chk("rb_dma_rdata", dma_rdata, 8'h33);
    tick();

    // Reset mid-read, then reset during a read grant.
    cpu_req = 1; cpu_rw = 0; cpu_addr = 8'h10;
    #1;
    chk("rst_rd_gnt", cpu_gnt, 1'b1);
    tick();
    reset = 1;
    #1;
    chk("rst_rvalid_dropped", cpu_rvalid, 1'b0);
    chk("rst_gnt_suppressed", cpu_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    tick();
    reset = 0;
    dma_req = 1; dma_addr = 8'h44;
    #1;
    chk("rst_tie_cpu", cpu_gnt, 1'b1);
    tick();
    idle_inputs();

    // Idle: no access, counters quiet, last kept (CPU won the tie).
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("idle_mem_en", mem_en, 1'b0);
      chk("idle_mem_addr", mem_addr, 8'h00);
      tick();
      chk("idle_hold", dut.hold_cnt_q, 4'd0);
      chk("idle_last", dut.last_q, 1'b0);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
